// File: rtl/hs_pkg.sv
// Shared declarations for the registered half subtractor.
// Widths above HS_MAX_WIDTH are outside the supported range.
package hs_pkg;
  localparam int HS_MAX_WIDTH = 64;
endpackage

// File: rtl/hs_if.sv
// Operand/result bundle for hs: master drives operands, slave returns results.
// The result side follows the operand side by exactly one clock.
interface hs_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic [WIDTH-1:0] sub;
  logic             br;

  modport master (
    output in_valid, x, y,
    input  out_valid, sub, br
  );

  modport slave (
    input  in_valid, x, y,
    output out_valid, sub, br
  );
endinterface

// File: rtl/hs_cell.sv
// Combinational 1-bit half subtractor: d = a - b, bo = borrow.
// Two of these plus an OR form one full-subtractor stage.
module hs_cell (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);
  assign d  = a ^ b;
  assign bo = ~a & b;
endmodule

// File: rtl/hs.sv
// Registered ripple-borrow subtractor with a synchronised reset release.
// WIDTH=1 reduces to the classic half subtractor.
module hs
  import hs_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  hs_if.slave  bus
);
  typedef struct packed {
    logic [WIDTH-1:0] sub;
    logic             br;
  } res_t;

  logic [WIDTH-1:0] w_d;
  logic [WIDTH:1]   w_b;
  res_t             w_res;
  res_t             r_res;
  logic             r_vld;
  logic             r_rdy;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      hs_cell u_c0 (
        .a  (bus.x[0]),
        .b  (bus.y[0]),
        .d  (w_d[0]),
        .bo (w_b[1])
      );
    end else begin : g_full
      logic w_d1;
      logic w_bo1;
      logic w_bo2;
      hs_cell u_ca (
        .a  (bus.x[i]),
        .b  (bus.y[i]),
        .d  (w_d1),
        .bo (w_bo1)
      );
      hs_cell u_cb (
        .a  (w_d1),
        .b  (w_b[i]),
        .d  (w_d[i]),
        .bo (w_bo2)
      );
      assign w_b[i+1] = w_bo1 | w_bo2;
    end
  end

  assign w_res = {w_d, w_b[WIDTH]};

  // Release takes one edge to propagate; capture starts on the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdy <= 1'b0;
    else        r_rdy <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
      r_vld <= 1'b0;
    end else if (r_rdy) begin
      r_vld <= bus.in_valid;
      if (bus.in_valid) r_res <= w_res;
    end
  end

  assign bus.out_valid = r_vld;
  assign bus.sub       = r_res.sub;
  assign bus.br        = r_res.br;
endmodule

// File: tb/tb_hs.sv
// Self-checking bench for hs at WIDTH=1 and WIDTH=8.
// Expected values come from vector tables and a plain-arithmetic model.
module tb_hs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hs_if #(.WIDTH(1)) b1 ();
  hs_if #(.WIDTH(8)) b8 ();

  hs #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  hs #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] sub;
    logic       br;
  } vec_t;

  vec_t t1[4];
  vec_t t8[4];

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  // Borrow is x<y; difference is x-y wrapped into w bits.
  function automatic logic [8:0] model(input int w, input logic [7:0] x,
                                       input logic [7:0] y);
    int unsigned m, xx, yy, d;
    m  = (1 << w) - 1;
    xx = int'(x) & m;
    yy = int'(y) & m;
    d  = (xx + (1 << w) - yy) & m;
    return {(xx < yy), d[7:0]};
  endfunction

  task automatic drv8(input logic v, input logic [7:0] x,
                      input logic [7:0] y);
    b8.in_valid = v;
    b8.x = x;
    b8.y = y;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] e;
    logic [8:0] q[$];
    int pulses;

    t1[0] = '{8'd0, 8'd0, 8'd0, 1'b0};
    t1[1] = '{8'd0, 8'd1, 8'd1, 1'b1};
    t1[2] = '{8'd1, 8'd0, 8'd1, 1'b0};
    t1[3] = '{8'd1, 8'd1, 8'd0, 1'b0};
    t8[0] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    t8[1] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    t8[2] = '{8'h80, 8'h80, 8'h00, 1'b0};
    t8[3] = '{8'h10, 8'h01, 8'h0F, 1'b0};

    b1.in_valid = 1'b0; b1.x = '0; b1.y = '0;
    drv8(1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b1.in_valid = 1'b1;
      b1.x = 1'($urandom);
      b1.y = 1'($urandom);
      drv8(1'b1, 8'($urandom), 8'($urandom));
      tick();
      chk("rst_ov1", b1.out_valid, 0);
      chk("rst_ov8", b8.out_valid, 0);
      chk("rst_sub8", b8.sub, 0);
      chk("rst_br8", b8.br, 0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    drv8(1'b1, 8'h05, 8'h03);
    tick();
    chk("rel_edge1_ov", b8.out_valid, 0);
    tick();
    chk("rel_edge2_ov", b8.out_valid, 1);
    chk("rel_edge2_sub", b8.sub, 8'h02);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b1.in_valid = 1'b1;
      b1.x = t1[i].x[0];
      b1.y = t1[i].y[0];
      tick();
      chk("w1_sub", b1.sub, t1[i].sub[0]);
      chk("w1_br", b1.br, t1[i].br);
      chk("w1_ov", b1.out_valid, 1);
      repeat (9) @(posedge clk);
    end
    @(negedge clk);
    b1.in_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drv8(1'b1, t8[i].x, t8[i].y);
      tick();
      chk("w8_sub", b8.sub, t8[i].sub);
      chk("w8_br", b8.br, t8[i].br);
      repeat (9) @(posedge clk);
    end

    @(negedge clk);
    drv8(1'b0, 8'h00, 8'h00);
    tick();
    pulses = 0;
    @(negedge clk);
    drv8(1'b1, 8'h37, 8'h12);
    for (int k = 0; k < 6; k++) begin
      tick();
      pulses += int'(b8.out_valid);
      @(negedge clk);
      drv8(1'b0, 8'($urandom), 8'($urandom));
    end
    chk("gate_pulses", pulses, 1);
    chk("gate_sub_hold", b8.sub, 8'h25);
    chk("gate_br_hold", b8.br, 0);
    b8.x = 'x;
    b8.y = 'z;
    tick();
    chk("xz_sub_hold", b8.sub, 8'h25);
    chk("xz_ov", b8.out_valid, 0);

    for (int n = 0; n < 256; n++) begin
      logic [7:0] xv, yv;
      @(negedge clk);
      xv = 8'($urandom);
      yv = 8'($urandom);
      q.push_back(model(8, xv, yv));
      drv8(1'b1, xv, yv);
      tick();
      e = q.pop_front();
      chk("stream_ov", b8.out_valid, 1);
      chk("stream_res", {b8.br, b8.sub}, e);
    end

    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (n == 4) drv8(1'b1, 8'h01, 8'h02);
      else drv8(1'b1, 8'($urandom), 8'($urandom));
      tick();
    end
    chk("mid_pre_br", b8.br, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_ov", b8.out_valid, 0);
    chk("mid_async_sub", b8.sub, 0);
    chk("mid_async_br", b8.br, 0);
    tick();
    chk("mid_held_ov", b8.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drv8(1'b1, 8'h40, 8'h01);
    tick();
    chk("mid_rel1_ov", b8.out_valid, 0);
    tick();
    chk("mid_rel2_ov", b8.out_valid, 1);
    e = model(8, 8'h40, 8'h01);
    chk("mid_rel2_res", {b8.br, b8.sub}, e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
